instruction_fetch_unit: RTL



---
 rtl/instruction_fetch_unit_if.sv | 50 +++++
 rtl/instruction_fetch_unit.sv | 118 +++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch unit, the instruction memory and the decode stage.
// The master side is the fetch unit and the slave side is the memory and decode side.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              stall;
  logic              branch_taken;
  logic [15:0]       branch_offset;
  logic              jump;
  logic [25:0]       jump_target;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] pc_out;
  logic              instr_valid;
  logic              halted;
  logic [CNT_W-1:0]  fetch_count;

  modport master (
    output imem_addr,
    input  imem_data,
    input  stall,
    input  branch_taken,
    input  branch_offset,
    input  jump,
    input  jump_target,
    output instr,
    output pc_out,
    output instr_valid,
    output halted,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output stall,
    output branch_taken,
    output branch_offset,
    output jump,
    output jump_target,
    input  instr,
    input  pc_out,
    input  instr_valid,
    input  halted,
    input  fetch_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the pc, reads the combinational instruction memory and registers the
// fetched word for decode. It handles stall, jump/branch squash, a halt opcode and a saturating count.
module instruction_fetch_unit #(
  parameter int          ADDR_W  = 5,
  parameter int          DATA_W  = 32,
  parameter logic [5:0]  HALT_OP = 6'b111111,
  parameter int          CNT_W   = 16
) (
  input logic                  clk,
  input logic                  reset,
  instruction_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [ADDR_W-1:0] branch_target;
  logic [CNT_W-1:0]  count_sat;
  logic              halt_word;
  logic              unused_bits;

  // The upper bits of the offset and target are outside the address space and are discarded.
  assign unused_bits = ^{bus.branch_offset[15:ADDR_W], bus.jump_target[25:ADDR_W]};

  // The branch is relative to the instruction in decode, not to the current fetch pc.
  assign branch_target = pc_out_q + ADDR_W'(1) + bus.branch_offset[ADDR_W-1:0];
  assign count_sat     = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
  assign halt_word     = (bus.imem_data[DATA_W-1:DATA_W-6] == HALT_OP);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    count_d  = count_q;

    case (state_q)
      INIT: begin
        state_d = RUN;
        valid_d = 1'b0;
      end

      RUN: begin
        if (bus.stall) begin
          state_d = RUN;
        end else if (bus.jump) begin
          pc_d    = bus.jump_target[ADDR_W-1:0];
          valid_d = 1'b0;
        end else if (bus.branch_taken) begin
          pc_d    = branch_target;
          valid_d = 1'b0;
        end else begin
          instr_d  = bus.imem_data;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          count_d  = count_sat;
          // A halt word is still issued, but the pc stays on it.
          if (halt_word) begin
            state_d = HALT;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end

      HALT: begin
        halted_d = 1'b1;
        valid_d  = 1'b0;
      end

      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= INIT;
      pc_q     <= '0;
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = halted_q;
  assign bus.fetch_count = count_q;

endmodule
